aes_mode_post: RTL
==================

# aes_mode_post

Output stage downstream of the AES control stage and the N_PIPES-lane AES core. It pairs each core result beat with the sideband beat the control stage emitted for the same input beat (chaining/plaintext word, keep, last), applies the mode-specific post-XOR, buffers results against downstream backpressure, and returns the CBC-encryption feedback IV to the control stage.

## Interface
- N_PIPES, 4, number of 128-bit lanes per beat
- MODE, 0, 0=ECB, 1=CTR, 2=CBC
- OPERATION, 0, 0=encrypt, 1=decrypt
- FIFO_DEPTH, 32, depth of the side FIFO and the result FIFO; power of 2, ≥4
- ALMOST_MARGIN, 8, slack reserved for core pipeline latency
- clk  in  1  clock
- resetn  in  1  reset, synchronous, active-low
- iside_valid  in  1  sideband beat from control stage
- iside_data  in  N_PIPES*128  chaining/plaintext word (control stage ocntr)
- iside_keep  in  N_PIPES*16  byte keep
- iside_last  in  1  last beat of message
- icore_valid  in  1  AES core result valid; the core cannot stall
- icore_data  in  N_PIPES*128  AES core result
- odata  out  N_PIPES*128  output beat
- okeep  out  N_PIPES*16  output keep
- olast  out  1  output last
- ovalid  out  1  output valid
- iready  in  1  downstream ready
- ofeedbackiv  out  128  CBC-encrypt chaining value
- ofeedbackvalid  out  1  one-cycle strobe for ofeedbackiv
- oalmost_full  out  1  result FIFO count ≥ FIFO_DEPTH-ALMOST_MARGIN
- oerr_overflow  out  1  sticky: a write was dropped because a FIFO was full
- oerr_underflow  out  1  sticky: core result arrived with the side FIFO empty

## Operation
- Side FIFO: pushes {iside_data, iside_keep, iside_last} on iside_valid. Pops exactly when icore_valid is high, so pairing is strictly in order.
- Combine register, loaded on icore_valid:
  - XOR_EN = (MODE==1) || (MODE==2 && OPERATION==1).
  - Result = icore_data ^ side_data if XOR_EN, else icore_data.
  - keep and last come from the side head.
- Underflow, meaning icore_valid with the side FIFO empty:
  - Side terms are taken as data 0, keep all-ones, last 0.
  - The beat is still produced and oerr_underflow is set.
- Result FIFO: pushes the combine register one cycle after icore_valid.
  - Push when full and no pop in the same cycle: beat dropped, oerr_overflow set.
  - Push and pop in the same cycle when full: both succeed.
  - The same drop rule applies to the side FIFO on iside_valid.
- Output: the result FIFO head drives odata/okeep/olast/ovalid. A beat transfers on ovalid && iready. While iready is low, odata/okeep/olast stay stable.
- Feedback: only when MODE==2 && OPERATION==0.
  - ofeedbackiv <= icore_data[N_PIPES*128-1 -: 128].
  - ofeedbackvalid pulses for one cycle, the cycle after icore_valid.
  - In all other modes ofeedbackvalid stays 0.
- Error flags are cleared only by reset.

## Timing
- Reset values: ovalid 0, odata 0, okeep 0, olast 0, ofeedbackiv 0, ofeedbackvalid 0, oalmost_full 0, oerr_overflow 0, oerr_underflow 0. Both FIFOs are empty after reset.
- Reset asserted mid-stream discards every buffered beat. Outputs hold reset values from the first clk edge with resetn low.
- icore_valid at cycle t:
  - Combine register valid at t+1.
  - Result FIFO write at t+1.
  - ovalid high at t+2 when the FIFO was empty. Minimum latency is 2 cycles.
- Feedback strobe at t+1. It never waits on iready.
- Throughput is one beat per cycle with iready held high.
- oalmost_full is registered and reflects the count after the previous cycle's push/pop.
- Side FIFO push and pop in the same cycle are both legal, including when it holds one entry.
- iside_valid and icore_valid for the same beat may coincide only if the side FIFO is non-empty. Same-cycle bypass is not supported and counts as underflow.

## Structure
- Shared package aes_pkg holds:
  - MODE_ECB/MODE_CTR/MODE_CBC and OP_ENC/OP_DEC constants
  - AES_BLOCK_W=128
  - a typed struct for the side beat {data, keep, last}
- One sub-module, aes_sync_fifo: parameterised width/depth, first-word-fall-through, count output, full/empty. It is instantiated twice, for the side FIFO and the result FIFO.
- The combine register, feedback logic and error flags live in the top level.

## Test plan
- **CTR XOR**, MODE=1: side data all 0x11 bytes, core data all 0xFF bytes -> odata all 0xEE bytes, okeep all-ones, ovalid 2 cycles after icore_valid.
- **ECB framing**, MODE=0: 3 beats with iside_last only on beat 3 -> odata equals core data; olast high on beat 3 only; ofeedbackvalid never high.
- **CBC-encrypt feedback**, MODE=2, OPERATION=0: core lane 3 = 128'hDEADBEEF_00000000_CAFEF00D_12345678 -> ofeedbackvalid high for exactly 1 cycle at t+1 with that value; odata equals core data.
- **Backpressure/overflow**, FIFO_DEPTH=32, ALMOST_MARGIN=8, iready=0: 33 core results -> oalmost_full set once 24 entries are held; beat 33 dropped and oerr_overflow=1; releasing iready drains beats 1..32 in order.
- **Underflow**: icore_valid with the side FIFO empty, MODE=2, OPERATION=1, core data 0xAB bytes -> odata all 0xAB bytes, okeep all-ones, oerr_underflow=1, flag sticky.
- **Reset mid-stream**: resetn low for 1 cycle with 5 beats buffered -> ovalid 0 next cycle, no stale beat emitted afterwards, error flags 0.

Source files
------------

// File: rtl/aes_pkg.sv
// Shared AES definitions: mode/operation encodings, block width and the
// sideband beat carried from the control stage to the post stage.
package aes_pkg;

   localparam int AES_BLOCK_W = 128;
   localparam int AES_N_PIPES = 4;

   localparam int MODE_ECB = 0;
   localparam int MODE_CTR = 1;
   localparam int MODE_CBC = 2;

   localparam int OP_ENC = 0;
   localparam int OP_DEC = 1;

   // Lane count is fixed by the package so the struct stays a plain packed type.
   typedef struct packed {
      logic [AES_N_PIPES*AES_BLOCK_W-1:0] data;
      logic [AES_N_PIPES*16-1:0]          keep;
      logic                               last;
   } side_beat_t;

endpackage

// File: rtl/aes_sync_fifo.sv
// Synchronous first-word-fall-through FIFO; the head reads as zero while empty
// so downstream outputs show clean values after reset.
module aes_sync_fifo #(
   parameter int  WIDTH    = 8,
   parameter int  DEPTH    = 32,
   parameter int  AF_LEVEL = DEPTH,
   localparam int AW       = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             resetn,
   input  logic             i_push,
   input  logic [WIDTH-1:0] i_data,
   input  logic             i_pop,
   output logic [WIDTH-1:0] o_data,
   output logic [AW:0]      o_count,
   output logic             o_full,
   output logic             o_empty,
   output logic             o_almost_full
);

   localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);
   localparam logic [AW:0] AF_C    = (AW+1)'(AF_LEVEL);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW-1:0]    r_wr_ptr;
   logic [AW-1:0]    r_rd_ptr;
   logic [AW:0]      r_count;
   logic [AW:0]      w_count_next;
   logic             r_almost_full;
   logic             w_push;
   logic             w_pop;

   assign o_empty = (r_count == '0);
   assign o_full  = (r_count == DEPTH_C);
   assign w_pop   = i_pop && !o_empty;
   // A full FIFO still accepts a write when the head leaves in the same cycle.
   assign w_push  = i_push && (!o_full || w_pop);

   always_comb begin
      w_count_next = r_count;
      if (w_push && !w_pop) begin
         w_count_next = r_count + 1'b1;
      end else if (w_pop && !w_push) begin
         w_count_next = r_count - 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         r_wr_ptr      <= '0;
         r_rd_ptr      <= '0;
         r_count       <= '0;
         r_almost_full <= 1'b0;
      end else begin
         if (w_push) begin
            r_wr_ptr <= r_wr_ptr + 1'b1;
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + 1'b1;
         end
         r_count       <= w_count_next;
         r_almost_full <= (w_count_next >= AF_C);
      end
   end

   always_ff @(posedge clk) begin
      if (w_push) begin
         r_mem[r_wr_ptr] <= i_data;
      end
   end

   assign o_data        = o_empty ? '0 : r_mem[r_rd_ptr];
   assign o_count       = r_count;
   assign o_almost_full = r_almost_full;

endmodule

// File: rtl/aes_mode_post.sv
// AES output stage: pairs core results with control-stage sideband beats,
// applies the mode post-XOR, buffers against backpressure and returns the CBC IV.
module aes_mode_post
   import aes_pkg::*;
#(
   parameter int N_PIPES       = AES_N_PIPES,
   parameter int MODE          = MODE_ECB,
   parameter int OPERATION     = OP_ENC,
   parameter int FIFO_DEPTH    = 32,
   parameter int ALMOST_MARGIN = 8
) (
   input  logic                         clk,
   input  logic                         resetn,
   input  logic                         iside_valid,
   input  logic [N_PIPES*AES_BLOCK_W-1:0] iside_data,
   input  logic [N_PIPES*16-1:0]        iside_keep,
   input  logic                         iside_last,
   input  logic                         icore_valid,
   input  logic [N_PIPES*AES_BLOCK_W-1:0] icore_data,
   output logic [N_PIPES*AES_BLOCK_W-1:0] odata,
   output logic [N_PIPES*16-1:0]        okeep,
   output logic                         olast,
   output logic                         ovalid,
   input  logic                         iready,
   output logic [AES_BLOCK_W-1:0]       ofeedbackiv,
   output logic                         ofeedbackvalid,
   output logic                         oalmost_full,
   output logic                         oerr_overflow,
   output logic                         oerr_underflow
);

   localparam int   DW     = N_PIPES*AES_BLOCK_W;
   localparam int   KW     = N_PIPES*16;
   localparam int   RW     = DW + KW + 1;
   localparam int   CW     = $clog2(FIFO_DEPTH) + 1;
   localparam logic XOR_EN = (MODE == MODE_CTR) || (MODE == MODE_CBC && OPERATION == OP_DEC);
   localparam logic FB_EN  = (MODE == MODE_CBC) && (OPERATION == OP_ENC);

   side_beat_t      w_side_in;
   side_beat_t      w_side_head;
   side_beat_t      w_side_sel;
   logic [CW-1:0]   w_side_count;
   logic            w_side_full;
   logic            w_side_empty;
   logic            w_side_af;
   logic            w_side_drop;

   logic [DW-1:0]   r_comb_data;
   logic [KW-1:0]   r_comb_keep;
   logic            r_comb_last;
   logic            r_comb_valid;

   logic [RW-1:0]   w_res_in;
   logic [RW-1:0]   w_res_head;
   logic [CW-1:0]   w_res_count;
   logic            w_res_full;
   logic            w_res_empty;
   logic            w_res_pop;
   logic            w_res_drop;

   logic [AES_BLOCK_W-1:0] r_fb_iv;
   logic            r_fb_valid;
   logic            r_err_overflow;
   logic            r_err_underflow;
   logic            w_unused_fifo;

   assign w_side_in = {iside_data, iside_keep, iside_last};

   aes_sync_fifo #(
      .WIDTH ($bits(side_beat_t)),
      .DEPTH (FIFO_DEPTH)
   ) u_side_fifo (
      .clk           (clk),
      .resetn        (resetn),
      .i_push        (iside_valid),
      .i_data        (w_side_in),
      .i_pop         (icore_valid),
      .o_data        (w_side_head),
      .o_count       (w_side_count),
      .o_full        (w_side_full),
      .o_empty       (w_side_empty),
      .o_almost_full (w_side_af)
   );

   // A core beat with no matching sideband still flows out with neutral side terms.
   always_comb begin
      w_side_sel = w_side_head;
      if (w_side_empty) begin
         w_side_sel.data = '0;
         w_side_sel.keep = '1;
         w_side_sel.last = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         r_comb_valid <= 1'b0;
         r_comb_data  <= '0;
         r_comb_keep  <= '0;
         r_comb_last  <= 1'b0;
      end else begin
         r_comb_valid <= icore_valid;
         if (icore_valid) begin
            r_comb_data <= XOR_EN ? (icore_data ^ w_side_sel.data) : icore_data;
            r_comb_keep <= w_side_sel.keep;
            r_comb_last <= w_side_sel.last;
         end
      end
   end

   assign w_res_in  = {r_comb_data, r_comb_keep, r_comb_last};
   assign w_res_pop = ovalid && iready;

   aes_sync_fifo #(
      .WIDTH    (RW),
      .DEPTH    (FIFO_DEPTH),
      .AF_LEVEL (FIFO_DEPTH - ALMOST_MARGIN)
   ) u_res_fifo (
      .clk           (clk),
      .resetn        (resetn),
      .i_push        (r_comb_valid),
      .i_data        (w_res_in),
      .i_pop         (w_res_pop),
      .o_data        (w_res_head),
      .o_count       (w_res_count),
      .o_full        (w_res_full),
      .o_empty       (w_res_empty),
      .o_almost_full (oalmost_full)
   );

   assign {odata, okeep, olast} = w_res_head;
   assign ovalid = !w_res_empty;

   // Full implies non-empty, so a pop request here is always an effective pop.
   assign w_side_drop = iside_valid && w_side_full && !icore_valid;
   assign w_res_drop  = r_comb_valid && w_res_full && !w_res_pop;

   always_ff @(posedge clk) begin
      if (!resetn) begin
         r_fb_iv         <= '0;
         r_fb_valid      <= 1'b0;
         r_err_overflow  <= 1'b0;
         r_err_underflow <= 1'b0;
      end else begin
         r_fb_valid <= FB_EN && icore_valid;
         if (FB_EN && icore_valid) begin
            r_fb_iv <= icore_data[DW-1 -: AES_BLOCK_W];
         end
         r_err_overflow  <= r_err_overflow || w_side_drop || w_res_drop;
         r_err_underflow <= r_err_underflow || (icore_valid && w_side_empty);
      end
   end

   assign ofeedbackiv    = r_fb_iv;
   assign ofeedbackvalid = r_fb_valid;
   assign oerr_overflow  = r_err_overflow;
   assign oerr_underflow = r_err_underflow;
   assign w_unused_fifo  = ^{w_side_count, w_side_af, w_res_count};

endmodule
